// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: instruction window geometry and the
// left-aligned byte window type consumed by the decoder.
package fetch_pkg;

  localparam int unsigned MAX_INST_BYTES = 15;
  localparam int unsigned FETCH_BYTES    = 8;

  typedef logic [0:MAX_INST_BYTES*8-1] inst_window_t;

endpackage

// File: rtl/fetch_window_rotator.sv
// Combinational window assembly: reads MAX_INST_BYTES bytes from the circular
// store starting at head, zeroing every position at or beyond count.
module fetch_window_rotator
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic [7:0]                 storage [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH):0]     count,
  output inst_window_t               window
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  always_comb begin
    window = '0;
    for (int i = 0; i < int'(MAX_INST_BYTES); i++) begin
      // Pointer arithmetic stays PtrW wide, so the read wraps modulo DEPTH.
      if (i < int'(count)) begin
        window[i*8 +: 8] = storage[head + PtrW'(i)];
      end
    end
  end

endmodule

// File: rtl/fetch_byte_queue.sv
// Instruction byte queue feeding the decoder: accepts 8-byte fetch words,
// presents the oldest 15 bytes as a window and retires consumed bytes.
module fetch_byte_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fill_valid,
  output logic         fill_ready,
  input  logic [63:0]  fill_data,
  input  logic [2:0]   fill_skip,
  output inst_window_t window,
  output logic [4:0]   window_count,
  output logic         window_full,
  input  logic         consume_en,
  input  logic [3:0]   consume,
  input  logic         flush,
  input  logic [63:0]  flush_pc,
  output logic [63:0]  pc,
  output logic         underflow_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      mem [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [63:0]     pc_q, pc_d;
  logic            err_q, err_d;

  logic       fill_fire, consume_ok, consume_bad;
  logic [3:0] fill_len;

  assign fill_ready  = (32'(count_q) + 32'(FETCH_BYTES)) <= DEPTH;
  assign fill_fire   = fill_valid && fill_ready && !flush;
  assign fill_len    = 4'd8 - {1'b0, fill_skip};
  assign consume_ok  = consume_en && (CntW'(consume) <= count_q);
  assign consume_bad = consume_en && (CntW'(consume) > count_q);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pc_d    = pc_q;
    err_d   = err_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = flush_pc;
      err_d   = 1'b0;
    end else begin
      if (fill_fire) begin
        tail_d = tail_q + PtrW'(fill_len);
      end
      if (consume_ok) begin
        head_d = head_q + PtrW'(consume);
        pc_d   = pc_q + 64'(consume);
      end
      count_d = count_q + (fill_fire ? CntW'(fill_len) : '0)
                        - (consume_ok ? CntW'(consume) : '0);
      err_d   = err_q | consume_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  // Storage is unreset; count masking keeps stale bytes off the window.
  always_ff @(posedge clk) begin
    if (fill_fire && !reset) begin
      for (int j = 0; j < int'(FETCH_BYTES); j++) begin
        if (3'(j) >= fill_skip) begin
          mem[tail_q + PtrW'(j) - PtrW'(fill_skip)] <= fill_data[j*8 +: 8];
        end
      end
    end
  end

  fetch_window_rotator #(
    .DEPTH(DEPTH)
  ) u_rotator (
    .storage(mem),
    .head   (head_q),
    .count  (count_q),
    .window (window)
  );

  assign window_full   = count_q >= CntW'(MAX_INST_BYTES);
  assign window_count  = window_full ? 5'(MAX_INST_BYTES) : 5'(count_q);
  assign pc            = pc_q;
  assign underflow_err = err_q;

endmodule
